alu_shift_sequencer: RTL and testbench
======================================

# alu_shift_sequencer

Multi-bit shift sequencer for the 16-bit ALU. It accepts a shift request (operand, amount 0–15, shift type) over a valid/ready handshake. It then drives the single-bit registered shift unit once per bit position, feeding each result back as the next operand. It returns the final word and carry over a second valid/ready handshake. The sequencer sits beside the shift unit in the ALU top level and is its only driver.

## Interface
- DATA_WIDTH, 16, operand/result width
- AMT_WIDTH, 4, shift-amount width (max amount 15)
- SHIFT_OUT_WIDTH, 17, width of shift-unit result bus
- CLK  in  1  clock, rising edge
- RST  in  1  reset; one clock, reset is asynchronous and active-high
- REQ_VALID  in  1  request present
- REQ_READY  out  1  sequencer can accept; equals (state==IDLE)
- REQ_DATA  in  DATA_WIDTH  operand
- REQ_AMT  in  AMT_WIDTH  number of bit positions
- REQ_OP  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROL
- SU_A  out  DATA_WIDTH  shift-unit A operand (registered working value)
- SU_B  out  DATA_WIDTH  tied to 0
- SU_EN  out  1  shift-unit enable, one cycle per bit
- SU_FUN  out  2  2'd0 (A>>1) for LSR/ASR, 2'd1 (A<<1) for LSL/ROL
- SU_OUT  in  SHIFT_OUT_WIDTH  shift-unit result, valid the cycle after SU_EN
- RES_VALID  out  1  result present
- RES_READY  in  1  consumer accepts result
- RES_DATA  out  DATA_WIDTH  shifted word
- RES_CARRY  out  1  last bit shifted out

## Operation
- **Shift-unit behaviour relied on:**
  - A is signed and sign-extended to 17 bits before the shift.
  - Right: SU_OUT[15:0] = {A[15], A[15:1]}.
  - Left: SU_OUT[16] = A[15], SU_OUT[15:0] = {A[14:0], 0}.
  - The unit's Shift_Flag is sticky, so it is not used. The sequencer counts cycles instead.
  - The top level drives the unit's reset with ~RST.
- **FSM states:** IDLE, ISSUE, WAIT, DONE.
- **IDLE:** REQ_READY=1. On REQ_VALID:
  - Latch work=REQ_DATA, cnt=REQ_AMT, op=REQ_OP, carry=0.
  - Go to DONE if REQ_AMT==0, else go to ISSUE.
- **ISSUE:** SU_EN=1, SU_A=work, SU_FUN per op. Go to WAIT.
- **WAIT:** SU_EN=0. At the edge, update work and carry per op, then decrement cnt:
  - LSL: work=SU_OUT[15:0], carry=SU_OUT[16].
  - LSR: work={0, SU_OUT[14:0]}, carry=work[0].
  - ASR: work=SU_OUT[15:0], carry=work[0].
  - ROL: work={SU_OUT[15:1], SU_OUT[16]}, carry=SU_OUT[16].
  - Next state: DONE if cnt==1, else ISSUE.
- **DONE:** RES_VALID=1, RES_DATA=work, RES_CARRY=carry, held stable until RES_READY. On RES_READY go to IDLE. No new request is accepted in DONE.
- REQ_* inputs are ignored when REQ_READY=0. RES_READY is ignored when RES_VALID=0.
- SU_A always reflects work and changes only at WAIT edges and at acceptance.

## Timing
- **Reset values:** state=IDLE, so REQ_READY=1 during and after reset. RES_VALID=0, RES_DATA=0, RES_CARRY=0, SU_EN=0, SU_A=0, SU_FUN=0, SU_B=0.
- **Latency:** acceptance edge ends cycle 0. RES_VALID first rises in cycle 2N+1 for amount N. Amount 0 gives cycle 1.
- **Duty cycle:** exactly N SU_EN pulses per request, never on consecutive cycles.
- **Throughput:** one request per 2N+2 cycles with RES_READY held high.
- **Backpressure:** DONE persists indefinitely while RES_READY=0, with outputs unchanged.
- **Reset mid-operation:** immediate return to IDLE and reset values. The in-flight result is discarded and no RES_VALID is produced. The shift unit resets concurrently.
- **Max amount:** 15 gives 30 busy cycles and RES_VALID in cycle 31.

## Structure
- Shared package alu_pkg holds:
  - shift op encodings (OP_LSL/LSR/ASR/ROL)
  - SU_FUN codes (SU_A_SHR=2'd0, SU_A_SHL=2'd1)
  - the sequencer state enum
  - DATA/AMT width constants
- No sub-module: FSM, counter and feedback fix-up are inline.
- The shift unit is instantiated by the ALU top level, not inside this block.

## Test plan
- **LSL:** LSL 0x8001 by 1 → RES_DATA=0x0002, RES_CARRY=1, RES_VALID in cycle 3, exactly one SU_EN pulse.
- **Right shifts:** ASR 0x8000 by 4 → 0xF800, carry 0. LSR 0x8000 by 4 → 0x0800, carry 0. Both give RES_VALID in cycle 9.
- **ROL:** ROL 0x8001 by 1 → 0x0003, carry 1. ROL 0x1234 by 15 → 0x091A, carry 0, RES_VALID in cycle 31.
- **Zero amount:** any op on 0x1234 by 0 → 0x1234, carry 0, RES_VALID in cycle 1, no SU_EN pulse.
- **Backpressure:** hold RES_READY=0 for 10 cycles after RES_VALID → RES_DATA/RES_CARRY stable, REQ_READY=0, and a new REQ_VALID is ignored. Release RES_READY → IDLE next cycle.
- **Mid-op reset:** assert RST in WAIT of LSL 0x00FF by 8 → all outputs at reset values asynchronously. No RES_VALID after deassertion, and REQ_READY=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: shift op encodings, shift-unit function codes,
// shift sequencer state encoding and datapath widths.
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int AMT_W  = 4;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    localparam logic [1:0] SU_A_SHR = 2'd0;
    localparam logic [1:0] SU_A_SHL = 2'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/alu_shift_sequencer.sv
// Multi-bit shifter built by iterating the single-bit registered shift unit,
// one ISSUE/WAIT pair per bit position, with valid/ready on both sides.
module alu_shift_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH      = DATA_W,
    parameter int AMT_WIDTH       = AMT_W,
    parameter int SHIFT_OUT_WIDTH = DATA_W + 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       REQ_VALID,
    output logic                       REQ_READY,
    input  logic [DATA_WIDTH-1:0]      REQ_DATA,
    input  logic [AMT_WIDTH-1:0]       REQ_AMT,
    input  logic [1:0]                 REQ_OP,
    output logic [DATA_WIDTH-1:0]      SU_A,
    output logic [DATA_WIDTH-1:0]      SU_B,
    output logic                       SU_EN,
    output logic [1:0]                 SU_FUN,
    input  logic [SHIFT_OUT_WIDTH-1:0] SU_OUT,
    output logic                       RES_VALID,
    input  logic                       RES_READY,
    output logic [DATA_WIDTH-1:0]      RES_DATA,
    output logic                       RES_CARRY
);

    seq_state_e            state;
    logic [DATA_WIDTH-1:0] work;
    logic [AMT_WIDTH-1:0]  cnt;
    logic [1:0]            op;
    logic                  carry;
    logic                  req_ready_r;
    logic                  su_en_r;
    logic [1:0]            su_fun_r;
    logic                  res_valid_r;

    assign REQ_READY = req_ready_r;
    assign SU_A      = work;
    assign SU_B      = '0;
    assign SU_EN     = su_en_r;
    assign SU_FUN    = su_fun_r;
    assign RES_VALID = res_valid_r;
    assign RES_DATA  = work;
    assign RES_CARRY = carry;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            work        <= '0;
            cnt         <= '0;
            op          <= OP_LSL;
            carry       <= 1'b0;
            req_ready_r <= 1'b1;
            su_en_r     <= 1'b0;
            su_fun_r    <= SU_A_SHR;
            res_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (REQ_VALID) begin
                        work        <= REQ_DATA;
                        cnt         <= REQ_AMT;
                        op          <= REQ_OP;
                        carry       <= 1'b0;
                        req_ready_r <= 1'b0;
                        su_fun_r    <= (REQ_OP == OP_LSR || REQ_OP == OP_ASR) ? SU_A_SHR : SU_A_SHL;
                        if (REQ_AMT == '0) begin
                            state       <= DONE;
                            res_valid_r <= 1'b1;
                        end else begin
                            state   <= ISSUE;
                            su_en_r <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    su_en_r <= 1'b0;
                    state   <= WAIT;
                end
                WAIT: begin
                    // The unit always sign-extends on right shifts and drops the
                    // wrapped bit on left shifts, so LSR and ROL are fixed up here.
                    case (op)
                        OP_LSL: begin
                            work  <= SU_OUT[DATA_WIDTH-1:0];
                            carry <= SU_OUT[DATA_WIDTH];
                        end
                        OP_LSR: begin
                            work  <= {1'b0, SU_OUT[DATA_WIDTH-2:0]};
                            carry <= work[0];
                        end
                        OP_ASR: begin
                            work  <= SU_OUT[DATA_WIDTH-1:0];
                            carry <= work[0];
                        end
                        default: begin
                            work  <= {SU_OUT[DATA_WIDTH-1:1], SU_OUT[DATA_WIDTH]};
                            carry <= SU_OUT[DATA_WIDTH];
                        end
                    endcase
                    cnt <= cnt - AMT_WIDTH'(1);
                    if (cnt == AMT_WIDTH'(1)) begin
                        state       <= DONE;
                        res_valid_r <= 1'b1;
                    end else begin
                        state   <= ISSUE;
                        su_en_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (RES_READY) begin
                        state       <= IDLE;
                        res_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Directed bench for alu_shift_sequencer with a behavioural single-bit shift unit.
module tb_alu_shift_sequencer;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_data;
    logic [3:0]  req_amt;
    logic [1:0]  req_op;
    logic [15:0] su_a;
    logic [15:0] su_b;
    logic        su_en;
    logic [1:0]  su_fun;
    logic [16:0] su_out;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_carry;

    int n_checks = 0;
    int n_fail   = 0;

    alu_shift_sequencer dut (
        .CLK       (clk),
        .RST       (rst),
        .REQ_VALID (req_valid),
        .REQ_READY (req_ready),
        .REQ_DATA  (req_data),
        .REQ_AMT   (req_amt),
        .REQ_OP    (req_op),
        .SU_A      (su_a),
        .SU_B      (su_b),
        .SU_EN     (su_en),
        .SU_FUN    (su_fun),
        .SU_OUT    (su_out),
        .RES_VALID (res_valid),
        .RES_READY (res_ready),
        .RES_DATA  (res_data),
        .RES_CARRY (res_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered single-bit shift unit: A sign-extended to 17 bits, then shifted.
    always @(posedge clk or posedge rst) begin
        if (rst)
            su_out <= '0;
        else if (su_en) begin
            if (su_fun == 2'd0)
                su_out <= {su_a[15], su_a[15], su_a[15:1]};
            else
                su_out <= {su_a, 1'b0};
        end
    end

    // Issue one request and observe until RES_VALID (sampled on falling edges).
    task automatic run_req(input logic [1:0] op, input logic [15:0] data, input logic [3:0] amt,
                           output logic [15:0] d, output logic c, output int cyc,
                           output int pulses, output bit consec);
        bit prev_en;
        bit seen;
        int k;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = data;
        req_amt   = amt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        pulses = 0; consec = 0; prev_en = 0; seen = 0; cyc = -1; d = '0; c = 1'b0;
        k = 0;
        while (!seen && k < 60) begin
            @(negedge clk);
            k++;
            if (su_en) begin
                pulses++;
                if (prev_en) consec = 1;
            end
            prev_en = su_en;
            if (res_valid) begin
                seen = 1;
                cyc  = k;
                d    = res_data;
                c    = res_carry;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_checks++;
        if ({req_ready, res_valid, res_data, res_carry, su_en, su_a, su_fun, su_b} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 2'd0, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_values: rdy=%b vld=%b data=%h carry=%b en=%b a=%h fun=%0d b=%h expected rdy=1 rest 0",
                     req_ready, res_valid, res_data, res_carry, su_en, su_a, su_fun, su_b);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset: rdy=%b vld=%b expected rdy=1 vld=0", req_ready, res_valid);
        end
    endtask

    task automatic test_vector(input string name, input logic [1:0] op, input logic [15:0] data,
                               input logic [3:0] amt, input logic [15:0] exp_d, input logic exp_c,
                               input int exp_cyc);
        logic [15:0] d;
        logic        c;
        int          cyc;
        int          pulses;
        bit          consec;
        run_req(op, data, amt, d, c, cyc, pulses, consec);
        n_checks++;
        if (d !== exp_d || c !== exp_c) begin
            n_fail++;
            $display("FAIL %s result: got %h/%b expected %h/%b", name, d, c, exp_d, exp_c);
        end
        n_checks++;
        if (cyc != exp_cyc) begin
            n_fail++;
            $display("FAIL %s latency: RES_VALID in cycle %0d expected %0d", name, cyc, exp_cyc);
        end
        n_checks++;
        if (pulses != int'(amt) || consec) begin
            n_fail++;
            $display("FAIL %s su_en: %0d pulses (back-to-back=%0d) expected %0d isolated", name, pulses, consec, amt);
        end
        // RES_READY is high, so the sequencer is idle again one edge later.
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s return_idle: rdy=%b vld=%b expected 1/0", name, req_ready, res_valid);
        end
    endtask

    task automatic test_lsl();
        test_vector("lsl_8001_1", OP_LSL, 16'h8001, 4'd1, 16'h0002, 1'b1, 3);
    endtask

    task automatic test_right_shifts();
        test_vector("asr_8000_4", OP_ASR, 16'h8000, 4'd4, 16'hF800, 1'b0, 9);
        test_vector("lsr_8000_4", OP_LSR, 16'h8000, 4'd4, 16'h0800, 1'b0, 9);
        test_vector("lsr_0003_1", OP_LSR, 16'h0003, 4'd1, 16'h0001, 1'b1, 3);
        test_vector("asr_4001_1", OP_ASR, 16'h4001, 4'd1, 16'h2000, 1'b1, 3);
    endtask

    task automatic test_rol();
        test_vector("rol_8001_1",  OP_ROL, 16'h8001, 4'd1,  16'h0003, 1'b1, 3);
        test_vector("rol_1234_15", OP_ROL, 16'h1234, 4'd15, 16'h091A, 1'b0, 31);
    endtask

    task automatic test_zero_amount();
        test_vector("zero_lsl", OP_LSL, 16'h1234, 4'd0, 16'h1234, 1'b0, 1);
        test_vector("zero_lsr", OP_LSR, 16'h1234, 4'd0, 16'h1234, 1'b0, 1);
        test_vector("zero_asr", OP_ASR, 16'h1234, 4'd0, 16'h1234, 1'b0, 1);
        test_vector("zero_rol", OP_ROL, 16'h1234, 4'd0, 16'h1234, 1'b0, 1);
    endtask

    task automatic test_backpressure();
        logic [15:0] d;
        logic        c;
        int          cyc;
        int          pulses;
        bit          consec;
        int          bad;
        res_ready = 1'b0;
        run_req(OP_ASR, 16'h8000, 4'd4, d, c, cyc, pulses, consec);
        n_checks++;
        if (cyc != 9 || d !== 16'hF800) begin
            n_fail++;
            $display("FAIL bp_first: cycle %0d data %h expected 9 F800", cyc, d);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin
                req_valid = 1'b1;
                req_data  = 16'h5555;
                req_amt   = 4'd3;
                req_op    = OP_LSL;
            end
            @(negedge clk);
            if (res_valid !== 1'b1 || res_data !== 16'hF800 || res_carry !== 1'b0 ||
                req_ready !== 1'b0 || su_en !== 1'b0)
                bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_hold: %0d unstable cycles (vld=%b data=%h rdy=%b) expected 0",
                     bad, res_valid, res_data, req_ready);
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0 || su_en !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: rdy=%b vld=%b en=%b expected 1/0/0", req_ready, res_valid, su_en);
        end
    endtask

    task automatic test_midop_reset();
        int bad;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_LSL;
        req_data  = 16'h00FF;
        req_amt   = 4'd8;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (su_a !== 16'h00FF || su_fun !== 2'd1 || su_en !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_wait: a=%h fun=%0d en=%b rdy=%b expected 00FF/1/0/0", su_a, su_fun, su_en, req_ready);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({req_ready, res_valid, res_data, res_carry, su_en, su_a, su_fun, su_b} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 2'd0, 16'h0}) begin
            n_fail++;
            $display("FAIL midop_async_reset: rdy=%b vld=%b data=%h a=%h fun=%0d expected rdy=1 rest 0",
                     req_ready, res_valid, res_data, su_a, su_fun);
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b0 || req_ready !== 1'b1 || su_en !== 1'b0)
                bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL midop_after_reset: %0d bad cycles (vld=%b rdy=%b) expected 0", bad, res_valid, req_ready);
        end
    endtask

    initial begin
        req_valid = 1'b0;
        req_data  = '0;
        req_amt   = '0;
        req_op    = OP_LSL;
        res_ready = 1'b1;
        test_reset();
        test_lsl();
        test_right_shifts();
        test_rol();
        test_zero_amount();
        test_backpressure();
        test_midop_reset();
        test_lsl();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
